downsample: RTL and testbench

2x2 stride-2 pooling stage for the feature datapath, the inverse of the 2x upsample stage. It consumes a row-major stream of `PE_ARRAY_SIZE`-lane feature beats for a `col_size` x `row_size` map and emits a `col_size/2` x `row_size/2` map, reducing each 2x2 window per lane with a signed max (or average, see Configuration). It sits between the feature output buffer and the next layer's input, with the same valid/ready stream interface on both sides.

---
 rtl/downsample.sv | 191 +++++++++++++++++++
 tb/tb_downsample.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/downsample.sv
// 2x2 stride-2 pooling of a row-major feature stream, signed max per lane by default.
// Define DOWNSAMPLE_AVG_EN to switch the reduction to 2x2 average pooling.
`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 8
`endif
`ifndef PE_ARRAY_SIZE
`define PE_ARRAY_SIZE 4
`endif

module downsample #(
  parameter int unsigned FEATURE_WIDTH       = `FEATURE_WIDTH,
  parameter int unsigned PE_ARRAY_SIZE       = `PE_ARRAY_SIZE,
  parameter int unsigned FEATURE_TOTAL_WIDTH = FEATURE_WIDTH * PE_ARRAY_SIZE,
  parameter int unsigned LINE_DEPTH          = 512,
  parameter int unsigned OUT_FIFO_DEPTH      = 16
) (
  input  logic                           system_clk,
  input  logic                           rst,
  input  logic [FEATURE_TOTAL_WIDTH-1:0] feature,
  input  logic                           feature_valid,
  output logic                           feature_ready,
  input  logic [9:0]                     col_size,
  input  logic [9:0]                     row_size,
  output logic [FEATURE_TOTAL_WIDTH-1:0] downsample_feature,
  output logic                           downsample_feature_valid,
  input  logic                           output_ready,
  output logic                           frame_done,
  output logic                           downsample_buffer_empty
);

  localparam int unsigned FW  = FEATURE_WIDTH;
  localparam int unsigned PE  = PE_ARRAY_SIZE;
`ifdef DOWNSAMPLE_AVG_EN
  localparam int unsigned HW  = FW + 1;  // line buffer keeps the 2-term partial sum
`else
  localparam int unsigned HW  = FW;
`endif
  localparam int unsigned AW  = $clog2(OUT_FIFO_DEPTH);
  localparam int unsigned LAW = $clog2(LINE_DEPTH);

  logic [9:0]                     col_cnt_q, col_cnt_d, row_cnt_q, row_cnt_d;
  logic [9:0]                     col_lim_q, col_lim_d, row_lim_q, row_lim_d;
  logic [FEATURE_TOTAL_WIDTH-1:0] pair_q, pair_d, pipe_q, pipe_d;
  logic                           pipe_valid_q, pipe_valid_d, frame_done_q, frame_done_d;
  logic [AW-1:0]                  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]                    count_q, count_d;

  logic [HW*PE-1:0]               line_mem [LINE_DEPTH];
  logic [FEATURE_TOTAL_WIDTH-1:0] fifo_mem [OUT_FIFO_DEPTH];

  logic                           accept, at_origin, dims_ok, last_col, last_row, line_we;
  logic [9:0]                     c_cur, r_cur;
  logic [LAW-1:0]                 line_addr;
  logic [HW*PE-1:0]               line_rd, h_vec;
  logic [FEATURE_TOTAL_WIDTH-1:0] o_vec;
  logic                           fifo_wr, fifo_rd;

  logic signed [FW-1:0]           a_l, b_l, o_l;
  logic signed [HW-1:0]           h_l, l_l;
  logic signed [FW+1:0]           s_l;

  // Ready reserves one slot for a result that may already sit in the pipeline register.
  assign feature_ready = !rst && (count_q <= (AW+1)'(OUT_FIFO_DEPTH - 2));
  assign accept        = feature_valid & feature_ready;
  assign at_origin     = (col_cnt_q == 10'd0) && (row_cnt_q == 10'd0);
  assign c_cur         = at_origin ? col_size : col_lim_q;
  assign r_cur         = at_origin ? row_size : row_lim_q;
  assign dims_ok       = (c_cur != 10'd0) && (r_cur != 10'd0);
  assign last_col      = (col_cnt_q == c_cur - 10'd1);
  assign last_row      = (row_cnt_q == r_cur - 10'd1);
  assign line_addr     = LAW'(col_cnt_q[9:1]);
  assign line_rd       = line_mem[line_addr];

  always_comb begin
    h_vec = '0;
    o_vec = '0;
    a_l   = '0;
    b_l   = '0;
    h_l   = '0;
    l_l   = '0;
    s_l   = '0;
    o_l   = '0;
    for (int i = 0; i < int'(PE); i++) begin
      a_l = pair_q[i*FW +: FW];
      b_l = feature[i*FW +: FW];
      l_l = line_rd[i*HW +: HW];
`ifdef DOWNSAMPLE_AVG_EN
      h_l = HW'(a_l) + HW'(b_l);
      s_l = (FW+2)'(h_l) + (FW+2)'(l_l);
      o_l = FW'(s_l >>> 2);
`else
      h_l = (a_l > b_l) ? a_l : b_l;
      o_l = (h_l > l_l) ? h_l : l_l;
`endif
      h_vec[i*HW +: HW] = h_l;
      o_vec[i*FW +: FW] = o_l;
    end
  end

  always_comb begin
    col_cnt_d    = col_cnt_q;
    row_cnt_d    = row_cnt_q;
    col_lim_d    = col_lim_q;
    row_lim_d    = row_lim_q;
    pair_d       = pair_q;
    pipe_d       = pipe_q;
    pipe_valid_d = 1'b0;
    frame_done_d = 1'b0;
    line_we      = 1'b0;
    if (accept) begin
      if (at_origin) begin
        col_lim_d = col_size;
        row_lim_d = row_size;
      end
      // Odd trailing rows/columns need no special case: they are never paired.
      if (dims_ok) begin
        if (!col_cnt_q[0]) begin
          pair_d = feature;
        end else if (!row_cnt_q[0]) begin
          line_we = 1'b1;
        end else begin
          pipe_d       = o_vec;
          pipe_valid_d = 1'b1;
        end
        if (last_col) begin
          col_cnt_d = 10'd0;
          if (last_row) begin
            row_cnt_d    = 10'd0;
            frame_done_d = 1'b1;
          end else begin
            row_cnt_d = row_cnt_q + 10'd1;
          end
        end else begin
          col_cnt_d = col_cnt_q + 10'd1;
        end
      end
    end
  end

  assign fifo_wr = pipe_valid_q;
  assign fifo_rd = downsample_feature_valid & output_ready;

  always_comb begin
    wptr_d  = fifo_wr ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = fifo_rd ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + {{AW{1'b0}}, fifo_wr} - {{AW{1'b0}}, fifo_rd};
  end

  always_ff @(posedge system_clk) begin
    if (rst) begin
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      col_lim_q    <= '0;
      row_lim_q    <= '0;
      pair_q       <= '0;
      pipe_q       <= '0;
      pipe_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
    end else begin
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      col_lim_q    <= col_lim_d;
      row_lim_q    <= row_lim_d;
      pair_q       <= pair_d;
      pipe_q       <= pipe_d;
      pipe_valid_q <= pipe_valid_d;
      frame_done_q <= frame_done_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge system_clk) begin
    if (line_we) line_mem[line_addr] <= h_vec;
    if (fifo_wr && !rst) fifo_mem[wptr_q] <= pipe_q;
  end

  always_ff @(posedge system_clk) begin
    if (!rst) assert (!(fifo_wr && !fifo_rd && count_q == (AW+1)'(OUT_FIFO_DEPTH)));
  end

  assign downsample_feature_valid = (count_q != '0);
  assign downsample_feature       = downsample_feature_valid ? fifo_mem[rptr_q] : '0;
  assign downsample_buffer_empty  = (count_q == '0) && !pipe_valid_q;
  assign frame_done               = frame_done_q;

endmodule

// File: tb/tb_downsample.sv
// Self-checking bench for downsample: directed and random frames against a window-level model.
module tb_downsample;
  localparam int FW = 8;
  localparam int PE = 4;
  localparam int TW = FW * PE;

  logic          system_clk = 1'b0;
  logic          rst = 1'b1;
  logic [TW-1:0] feature = '0;
  logic          feature_valid = 1'b0;
  logic          feature_ready;
  logic [9:0]    col_size = 10'd4;
  logic [9:0]    row_size = 10'd4;
  logic [TW-1:0] downsample_feature;
  logic          downsample_feature_valid;
  logic          output_ready = 1'b1;
  logic          frame_done;
  logic          downsample_buffer_empty;

  downsample #(
    .FEATURE_WIDTH      (FW),
    .PE_ARRAY_SIZE      (PE),
    .FEATURE_TOTAL_WIDTH(TW),
    .LINE_DEPTH         (512),
    .OUT_FIFO_DEPTH     (16)
  ) dut (
    .system_clk              (system_clk),
    .rst                     (rst),
    .feature                 (feature),
    .feature_valid           (feature_valid),
    .feature_ready           (feature_ready),
    .col_size                (col_size),
    .row_size                (row_size),
    .downsample_feature      (downsample_feature),
    .downsample_feature_valid(downsample_feature_valid),
    .output_ready            (output_ready),
    .frame_done              (frame_done),
    .downsample_buffer_empty (downsample_buffer_empty)
  );

  always #5 system_clk = ~system_clk;

  int n_tests = 0;
  int n_fail = 0;
  int step_n = 0;
  int last_acc_step = 0;
  int fd_cnt = 0;
  int fd_step = 0;
  int first_valid_step = -1;
  bit acc_now = 1'b0;
  logic [TW-1:0] beats[$];
  logic [TW-1:0] expq[$];
  logic [TW-1:0] gotq[$];
  int acc_steps[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge system_clk);
    acc_now = feature_valid && feature_ready;
    if (acc_now) last_acc_step = step_n;
    if (downsample_feature_valid && output_ready) gotq.push_back(downsample_feature);
    if (downsample_feature_valid && first_valid_step < 0) first_valid_step = step_n;
    if (frame_done) begin
      fd_cnt++;
      fd_step = step_n;
    end
    @(posedge system_clk);
    #1;
    step_n++;
  endtask

  function automatic int lane(input logic [TW-1:0] b, input int l);
    logic signed [FW-1:0] t;
    t = b[l*FW +: FW];
    return int'(t);
  endfunction

  // Expected pooled beats: each output (y,x) reduces input rows 2y..2y+1, cols 2x..2x+1.
  function automatic void model(input int c, input int r);
    for (int y = 0; y < r / 2; y++) begin
      for (int x = 0; x < c / 2; x++) begin
        logic [TW-1:0] o;
        o = '0;
        for (int l = 0; l < PE; l++) begin
          int v0, v1, v2, v3, res;
          v0 = lane(beats[(2*y)*c + 2*x], l);
          v1 = lane(beats[(2*y)*c + 2*x + 1], l);
          v2 = lane(beats[(2*y+1)*c + 2*x], l);
          v3 = lane(beats[(2*y+1)*c + 2*x + 1], l);
`ifdef DOWNSAMPLE_AVG_EN
          res = (v0 + v1 + v2 + v3) >>> 2;
`else
          res = v0;
          if (v1 > res) res = v1;
          if (v2 > res) res = v2;
          if (v3 > res) res = v3;
`endif
          o[l*FW +: FW] = res[FW-1:0];
        end
        expq.push_back(o);
      end
    end
  endfunction

  task automatic begin_frame();
    beats.delete();
    expq.delete();
    gotq.delete();
    acc_steps.delete();
    fd_cnt = 0;
    first_valid_step = -1;
  endtask

  task automatic gen_beats(input int nb, input bit idx_lane0);
    for (int i = 0; i < nb; i++) begin
      logic [TW-1:0] b;
      for (int l = 0; l < PE; l++) begin
        logic [31:0] rv;
        rv = $urandom;
        b[l*FW +: FW] = (idx_lane0 && l == 0) ? FW'(i) : rv[FW-1:0];
      end
      beats.push_back(b);
    end
  endtask

  task automatic send_frame(input int c, input int r, input bit gaps, input bit or_rand,
                            input bit hold, input int alt_at, input int alt_c);
    int i, idle, budget;
    bit released;
    i = 0;
    idle = 0;
    budget = 0;
    released = !hold;
    col_size = 10'(c);
    row_size = 10'(r);
    while (i < beats.size() && budget < 5000) begin
      feature = beats[i];
      feature_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      output_ready = !released ? 1'b0 : (or_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      step();
      budget++;
      if (acc_now) begin
        acc_steps.push_back(last_acc_step);
        i++;
        idle = 0;
        if (i == alt_at) col_size = 10'(alt_c);
      end else if (feature_valid) begin
        idle++;
      end
      if (!released && idle >= 20) begin
        chk("stall_ready_low", feature_ready, 0);
        chk("stall_out_valid", downsample_feature_valid, 1);
        chk("stall_before_end", i < beats.size(), 1);
        released = 1'b1;
      end
    end
    feature_valid = 1'b0;
    chk("all_beats_accepted", i, beats.size());
    if (hold) chk("stall_seen", released, 1);
  endtask

  task automatic drain(input int fd_exp);
    int n;
    feature_valid = 1'b0;
    output_ready = 1'b1;
    for (int k = 0; k < 300 && gotq.size() < expq.size(); k++) step();
    repeat (4) step();
    chk("out_count", gotq.size(), expq.size());
    n = (gotq.size() < expq.size()) ? gotq.size() : expq.size();
    for (int k = 0; k < n; k++) chk($sformatf("out_beat%0d", k), gotq[k], expq[k]);
    chk("frame_done_count", fd_cnt, fd_exp);
    if (fd_exp > 0) chk("frame_done_timing", fd_step, last_acc_step + 1);
    chk("buffer_empty_end", downsample_buffer_empty, 1);
  endtask

  initial begin
    int t1[4];
    t1 = '{5, 7, 13, 15};

    // Reset state
    repeat (3) @(posedge system_clk);
    #1;
    chk("rst_ready", feature_ready, 0);
    chk("rst_valid", downsample_feature_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_empty", downsample_buffer_empty, 1);
    chk("rst_data", downsample_feature, 0);
    rst = 1'b0;
    @(posedge system_clk);
    #1;
    chk("ready_after_rst", feature_ready, 1);

    // 4x4 with lane0 = beat index
    begin_frame();
    gen_beats(16, 1'b1);
    model(4, 4);
    send_frame(4, 4, 1'b0, 1'b0, 1'b0, -1, 0);
    drain(1);
    if (acc_steps.size() > 5) chk("latency_beat5", first_valid_step - acc_steps[5], 2);
`ifndef DOWNSAMPLE_AVG_EN
    for (int k = 0; k < 4; k++)
      if (gotq.size() > k) chk($sformatf("t1_lane0_%0d", k), gotq[k][7:0], 8'(t1[k]));
`endif

    // Signed 2x2 window
    begin_frame();
    gen_beats(4, 1'b0);
`ifdef DOWNSAMPLE_AVG_EN
    beats[0][7:0] = 8'hFF;
    beats[1][7:0] = 8'hFE;
    beats[2][7:0] = 8'h00;
    beats[3][7:0] = 8'h00;
`else
    beats[0][7:0] = 8'hFD;
    beats[1][7:0] = 8'hF8;
    beats[2][7:0] = 8'hFF;
    beats[3][7:0] = 8'h80;
`endif
    model(2, 2);
    send_frame(2, 2, 1'b0, 1'b0, 1'b0, -1, 0);
    drain(1);
    if (gotq.size() > 0) chk("signed_lane0", gotq[0][7:0], 8'hFF);

    // 5x3 odd dimensions, random gaps and output backpressure
    begin_frame();
    gen_beats(15, 1'b0);
    model(5, 3);
    send_frame(5, 3, 1'b1, 1'b1, 1'b0, -1, 0);
    drain(1);

    // 8x8 with output held off until input stalls
    begin_frame();
    gen_beats(64, 1'b0);
    model(8, 8);
    send_frame(8, 8, 1'b0, 1'b0, 1'b1, -1, 0);
    drain(1);

    // Reset mid row 1, then a fresh frame
    begin_frame();
    gen_beats(6, 1'b0);
    send_frame(4, 4, 1'b0, 1'b0, 1'b0, -1, 0);
    rst = 1'b1;
    #1;
    chk("midrst_ready_low", feature_ready, 0);
    @(posedge system_clk);
    #1;
    rst = 1'b0;
    chk("midrst_empty", downsample_buffer_empty, 1);
    chk("midrst_valid", downsample_feature_valid, 0);
    begin_frame();
    gen_beats(16, 1'b0);
    model(4, 4);
    send_frame(4, 4, 1'b0, 1'b0, 1'b0, -1, 0);
    drain(1);

    // col_size changed mid-frame takes effect only on the next frame
    begin_frame();
    gen_beats(16, 1'b0);
    model(4, 4);
    send_frame(4, 4, 1'b0, 1'b0, 1'b0, 3, 8);
    drain(1);
    begin_frame();
    gen_beats(32, 1'b0);
    model(8, 4);
    send_frame(8, 4, 1'b1, 1'b0, 1'b0, -1, 0);
    drain(1);

    // Degenerate sizes
    begin_frame();
    gen_beats(3, 1'b0);
    model(1, 3);
    send_frame(1, 3, 1'b0, 1'b0, 1'b0, -1, 0);
    drain(1);
    begin_frame();
    gen_beats(5, 1'b0);
    model(0, 4);
    send_frame(0, 4, 1'b0, 1'b0, 1'b0, -1, 0);
    drain(0);
    begin_frame();
    gen_beats(5, 1'b0);
    model(4, 0);
    send_frame(4, 0, 1'b0, 1'b0, 1'b0, -1, 0);
    drain(0);

    // Random frames
    for (int f = 0; f < 5; f++) begin
      int c, r;
      c = $urandom_range(2, 10);
      r = $urandom_range(2, 8);
      begin_frame();
      gen_beats(c * r, 1'b0);
      model(c, r);
      send_frame(c, r, 1'b1, 1'b1, 1'b0, -1, 0);
      drain(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
